// File: rtl/sysid_regbank_if.sv
// Avalon-MM bus bundle between the CPU data master and the sysid register bank.
// Latency: none, wires only.
// Backpressure: none; the slave has no waitrequest, so every strobe is accepted.
//
// Signals: address (word), read/write strobes, writedata, byteenable,
//          readdata and readdatavalid returned by the slave.
interface sysid_regbank_if #(
  parameter int ADDR_W = 3
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regbank.sv
// System-ID register bank: build ID, timestamp, version, scratch, 64-bit uptime.
// Latency: readdatavalid READ_LATENCY cycles after the read strobe.
// Backpressure: none; reads and writes are accepted in the cycle presented.
//
// Ports: clock, reset (synchronous, active-high), bus (Avalon-MM slave modport).
// Map: 0 SYSTEM_ID, 1 TIMESTAMP, 2 {VER_MAJOR,VER_MINOR}, 3 scratch (RW),
//      4 uptime[31:0] (loads shadow), 5 shadow, 6 control (RW), 7+ reads 0.
module sysid_regbank #(
  parameter logic [31:0] SYSTEM_ID    = 32'd21,
  parameter logic [31:0] TIMESTAMP    = 32'd0,
  parameter logic [15:0] VER_MAJOR    = 16'd2,
  parameter logic [15:0] VER_MINOR    = 16'd0,
  parameter logic [31:0] SCRATCH_INIT = 32'h0,
  parameter int          ADDR_W       = 3,
  parameter int          READ_LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset,
  sysid_regbank_if.slave  bus
);

  if (ADDR_W < 3) begin : g_bad_addr_w
    $error("sysid_regbank: ADDR_W must be >= 3");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("sysid_regbank: READ_LATENCY must be 1..4");
  end

  logic [31:0] scratch;
  logic [63:0] uptime;
  logic [31:0] shadow;
  logic        freeze;

  logic [31:0] rd_val;
  logic        in_map;
  logic [2:0]  word;
  logic        wr_scratch;
  logic        wr_ctrl;
  logic        rd_lo;
  logic        uptime_clr;
  logic        freeze_set;

  // Any set bit above the low three address bits lands outside the map.
  assign in_map     = ((bus.address >> 3) == ADDR_W'(0));
  assign word       = bus.address[2:0];
  assign wr_scratch = bus.write && in_map && (word == 3'd3);
  assign wr_ctrl    = bus.write && in_map && (word == 3'd6) && bus.byteenable[0];
  assign rd_lo      = bus.read  && in_map && (word == 3'd4);
  assign uptime_clr = wr_ctrl && bus.writedata[0];
  assign freeze_set = wr_ctrl && bus.writedata[1];

  // Read mux sees only current register state, so a read coinciding with a
  // write returns the pre-write value.
  always_comb begin
    rd_val = '0;
    if (in_map) begin
      case (word)
        3'd0:    rd_val = SYSTEM_ID;
        3'd1:    rd_val = TIMESTAMP;
        3'd2:    rd_val = {VER_MAJOR, VER_MINOR};
        3'd3:    rd_val = scratch;
        3'd4:    rd_val = uptime[31:0];
        3'd5:    rd_val = shadow;
        3'd6:    rd_val = {30'b0, freeze, 1'b0};
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch <= SCRATCH_INIT;
      uptime  <= '0;
      shadow  <= '0;
      freeze  <= 1'b0;
    end else begin
      // Clear beats the increment in the same cycle.
      if (uptime_clr) begin
        uptime <= '0;
      end else if (!freeze) begin
        uptime <= uptime + 64'd1;
      end

      // Low-word read latches the high word of the same sample so the
      // following shadow read forms a coherent 64-bit pair.
      if (uptime_clr) begin
        shadow <= '0;
      end else if (rd_lo) begin
        shadow <= uptime[63:32];
      end

      // Freeze is sticky until reset.
      if (freeze_set) begin
        freeze <= 1'b1;
      end

      if (wr_scratch) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.byteenable[b]) begin
            scratch[8*b +: 8] <= bus.writedata[8*b +: 8];
          end
        end
      end
    end
  end

  // Read return pipeline; data is zeroed at entry so idle slots carry 0.
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [31:0]             dat_pipe [READ_LATENCY];

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= bus.read;
      dat_pipe[0] <= bus.read ? rd_val : 32'd0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign bus.readdata      = dat_pipe[READ_LATENCY-1];
  assign bus.readdatavalid = vld_pipe[READ_LATENCY-1];

endmodule

// File: doc/sysid_regbank.md
Name: sysid_regbank

Overview:
- Parametrised successor to the fixed two-word system-ID slave: an Avalon-MM register bank that identifies the build and reports uptime.
- Returns system ID, build timestamp and version, and provides a byte-writable scratch register plus a 64-bit free-running uptime counter with coherent snapshot reads.
- Has a fixed, configurable read latency with readdatavalid.
- Sits on the CPU data master next to the other control slaves; firmware reads it at boot for build identification and at runtime for timekeeping.

Parameters:
- SYSTEM_ID, 32'd21: value of register 0.
- TIMESTAMP, 32'd0: build timestamp, register 1.
- VER_MAJOR, 16'd2: upper half of register 2.
- VER_MINOR, 16'd0: lower half of register 2.
- SCRATCH_INIT, 32'h0: reset value of the scratch register.
- ADDR_W, 3: word-address width; must be >= 3.
- READ_LATENCY, 1: cycles from read to readdatavalid; legal values 1..4.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe, one cycle per transfer.
- write  in  1  write strobe, one cycle per transfer.
- writedata  in  32  write data.
- byteenable  in  4  write byte lanes.
- readdata  out  32  read data; valid only while readdatavalid is high.
- readdatavalid  out  1  one-cycle pulse per accepted read.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- State on reset:
  - readdata = 0 and readdatavalid = 0.
  - Read pipeline flushed.
  - scratch = SCRATCH_INIT.
  - uptime = 0, shadow = 0, freeze = 0.
- No waitrequest. Every read and every write is accepted in the cycle it is presented.
- Register map (word address, access, content):
  - 0, RO: SYSTEM_ID.
  - 1, RO: TIMESTAMP.
  - 2, RO: {VER_MAJOR, VER_MINOR}.
  - 3, RW: scratch. Each lane where byteenable[i]=1 updates byte i; other bytes keep their value.
  - 4, RO: uptime[31:0]. The read also loads shadow <= uptime[63:32], sampled in the same cycle.
  - 5, RO: shadow. uptime is not sampled on this read.
  - 6, RW: control.
    - Write bit0=1 clears uptime and shadow to 0 (self-clearing, reads back 0).
    - Write bit1 sets freeze; byteenable[0] must be set for either bit to take effect.
    - Read returns {30'b0, freeze, 1'b0}.
  - 7 and above: read 0. Writes are ignored.
- Writes to RO registers are ignored without error.
- Uptime counter:
  - 64-bit. Increments by 1 every cycle while freeze=0 and reset=0.
  - Wraps from 2^64-1 to 0.
  - A clear and an increment in the same cycle: the clear wins, so the counter reads 0 in the next cycle.
- Read pipeline:
  - The read value is sampled in the cycle read is high (cycle T).
  - It is shifted through READ_LATENCY register stages, so readdatavalid=1 with that data at T+READ_LATENCY.
  - Back-to-back reads on every cycle are supported at full throughput, and order is preserved.
  - readdata is forced to 0 in any cycle readdatavalid=0.
- Simultaneous read and write in the same cycle:
  - The read returns the pre-write value.
  - The write takes effect in the next cycle.
  - Scratch example: a read and write to address 3 in cycle T; the read returns the old value, and a later read returns the new value.
- Reset during a read: any in-flight reads are discarded. readdatavalid stays 0 from the cycle after reset is sampled until new reads arrive.
- Coherent 64-bit uptime read: read address 4, then address 5. Any number of cycles may elapse between them, and the pair is consistent. A second read of address 4 overwrites shadow.

Test Plan:
1. Release reset at READ_LATENCY=1; read addresses 0, 1, 2 on consecutive cycles -> readdatavalid high on 3 consecutive cycles with 21, TIMESTAMP, {VER_MAJOR,VER_MINOR}=32'h00020000.
2. Write 32'hAABBCCDD to address 3 with byteenable=4'hF, then write 32'h11223344 with byteenable=4'b0101 -> a read of address 3 returns 32'hAA22CC44. A simultaneous read+write in the same cycle returns the old value.
3. Force uptime to 64'h0000_0000_FFFF_FFFE by waiting or by preload in simulation. Read address 4, wait 10 cycles, read address 5 -> the low word equals the sampled value and the high word equals 0. The lo/hi pair stays consistent across the 32-bit carry.
4. Write 2'b10 to control, read address 4 twice 20 cycles apart -> identical values. Write 2'b01 in the same cycle the counter would increment -> the next read of address 4 returns 0 and the counter stays frozen.
5. Set READ_LATENCY=3 and issue 4 back-to-back reads -> readdatavalid is high for 4 cycles starting 3 cycles after the first read, in order. Assert reset with 2 reads in flight -> no readdatavalid pulses follow.
6. Read addresses 7 and 6 after a write to address 0 -> 0 and {30'b0,freeze,0} respectively. Address 0 still reads SYSTEM_ID.
